// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline boundary bundle: ID-side capture fields, WB write-back port,
// pipeline control (Stall/Flush) and the registered EX-side outputs.
interface id_ex_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 8
);
    // Pipeline control
    logic              Stall;
    logic              Flush;

    // ID stage capture fields
    logic              ID_valid;
    logic [CTRL_W-1:0] ID_Ctrl;
    logic [DATA_W-1:0] ID_PC_plus4;
    logic [REG_AW-1:0] ID_Rs;
    logic [REG_AW-1:0] ID_Rt;
    logic [REG_AW-1:0] ID_Rd;
    logic [DATA_W-1:0] ID_Read_data_1;
    logic [DATA_W-1:0] ID_Read_data_2;
    logic [DATA_W-1:0] ID_Imm_ext;

    // WB stage register-file write port
    logic              WB_RegWrite;
    logic [REG_AW-1:0] WB_Write_register;
    logic [DATA_W-1:0] WB_Write_data;

    // EX stage view
    logic              EX_valid;
    logic [CTRL_W-1:0] EX_Ctrl;
    logic [DATA_W-1:0] EX_PC_plus4;
    logic [DATA_W-1:0] EX_Imm_ext;
    logic [REG_AW-1:0] EX_Rs;
    logic [REG_AW-1:0] EX_Rt;
    logic [REG_AW-1:0] EX_Rd;
    logic [DATA_W-1:0] EX_Read_data_1;
    logic [DATA_W-1:0] EX_Read_data_2;

    modport master (
        output Stall, Flush,
        output ID_valid, ID_Ctrl, ID_PC_plus4, ID_Rs, ID_Rt, ID_Rd,
        output ID_Read_data_1, ID_Read_data_2, ID_Imm_ext,
        output WB_RegWrite, WB_Write_register, WB_Write_data,
        input  EX_valid, EX_Ctrl, EX_PC_plus4, EX_Imm_ext,
        input  EX_Rs, EX_Rt, EX_Rd, EX_Read_data_1, EX_Read_data_2
    );

    modport slave (
        input  Stall, Flush,
        input  ID_valid, ID_Ctrl, ID_PC_plus4, ID_Rs, ID_Rt, ID_Rd,
        input  ID_Read_data_1, ID_Read_data_2, ID_Imm_ext,
        input  WB_RegWrite, WB_Write_register, WB_Write_data,
        output EX_valid, EX_Ctrl, EX_PC_plus4, EX_Imm_ext,
        output EX_Rs, EX_Rt, EX_Rd, EX_Read_data_1, EX_Read_data_2
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with WB->ID bypass on capture and WB refresh while stalled.
// Optional macro ID_EX_ZERO_REG_EN makes register $0 hardwired to zero.
module id_ex_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    id_ex_reg_if.slave bus
);

    logic              valid_q,       valid_d;
    logic [CTRL_W-1:0] ctrl_q,        ctrl_d;
    logic [DATA_W-1:0] pc_plus4_q,    pc_plus4_d;
    logic [DATA_W-1:0] imm_ext_q,     imm_ext_d;
    logic [REG_AW-1:0] rs_q,          rs_d;
    logic [REG_AW-1:0] rt_q,          rt_d;
    logic [REG_AW-1:0] rd_q,          rd_d;
    logic [DATA_W-1:0] read_data_1_q, read_data_1_d;
    logic [DATA_W-1:0] read_data_2_q, read_data_2_d;

    logic [DATA_W-1:0] load_op1;
    logic [DATA_W-1:0] load_op2;

    // True when the WB write this cycle targets register spec.
    function automatic logic wb_hit(
        input logic              we,
        input logic [REG_AW-1:0] wa,
        input logic [REG_AW-1:0] spec
    );
`ifdef ID_EX_ZERO_REG_EN
        return we && (wa == spec) && (spec != '0);
`else
        return we && (wa == spec);
`endif
    endfunction

    // Operands as they should be captured on a load, corrected for the
    // register file's read-before-write behaviour.
    always_comb begin
        load_op1 = wb_hit(bus.WB_RegWrite, bus.WB_Write_register, bus.ID_Rs)
                   ? bus.WB_Write_data : bus.ID_Read_data_1;
        load_op2 = wb_hit(bus.WB_RegWrite, bus.WB_Write_register, bus.ID_Rt)
                   ? bus.WB_Write_data : bus.ID_Read_data_2;
`ifdef ID_EX_ZERO_REG_EN
        if (bus.ID_Rs == '0) load_op1 = '0;
        if (bus.ID_Rt == '0) load_op2 = '0;
`endif
    end

    always_comb begin
        // NOTE: every _d gets a default (hold) first so no path leaves it unassigned and infers a latch.
        valid_d       = valid_q;
        ctrl_d        = ctrl_q;
        pc_plus4_d    = pc_plus4_q;
        imm_ext_d     = imm_ext_q;
        rs_d          = rs_q;
        rt_d          = rt_q;
        rd_d          = rd_q;
        read_data_1_d = read_data_1_q;
        read_data_2_d = read_data_2_q;

        if (bus.Flush) begin
            valid_d       = 1'b0;
            ctrl_d        = '0;
            pc_plus4_d    = '0;
            imm_ext_d     = '0;
            rs_d          = '0;
            rt_d          = '0;
            rd_d          = '0;
            read_data_1_d = '0;
            read_data_2_d = '0;
        end else if (bus.Stall) begin
            // Held operands track WB writes so EX does not consume stale data.
            if (valid_q && wb_hit(bus.WB_RegWrite, bus.WB_Write_register, rs_q))
                read_data_1_d = bus.WB_Write_data;
            if (valid_q && wb_hit(bus.WB_RegWrite, bus.WB_Write_register, rt_q))
                read_data_2_d = bus.WB_Write_data;
        end else begin
            valid_d       = bus.ID_valid;
            ctrl_d        = bus.ID_valid ? bus.ID_Ctrl : '0;
            pc_plus4_d    = bus.ID_PC_plus4;
            imm_ext_d     = bus.ID_Imm_ext;
            rs_d          = bus.ID_Rs;
            rt_d          = bus.ID_Rt;
            rd_d          = bus.ID_Rd;
            read_data_1_d = load_op1;
            read_data_2_d = load_op2;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) begin
            valid_q       <= 1'b0;
            ctrl_q        <= '0;
            pc_plus4_q    <= '0;
            imm_ext_q     <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            rd_q          <= '0;
            read_data_1_q <= '0;
            read_data_2_q <= '0;
        end else begin
            valid_q       <= valid_d;
            ctrl_q        <= ctrl_d;
            pc_plus4_q    <= pc_plus4_d;
            imm_ext_q     <= imm_ext_d;
            rs_q          <= rs_d;
            rt_q          <= rt_d;
            rd_q          <= rd_d;
            read_data_1_q <= read_data_1_d;
            read_data_2_q <= read_data_2_d;
        end
    end

    assign bus.EX_valid       = valid_q;
    assign bus.EX_Ctrl        = ctrl_q;
    assign bus.EX_PC_plus4    = pc_plus4_q;
    assign bus.EX_Imm_ext     = imm_ext_q;
    assign bus.EX_Rs          = rs_q;
    assign bus.EX_Rt          = rt_q;
    assign bus.EX_Rd          = rd_q;
    assign bus.EX_Read_data_1 = read_data_1_q;
    assign bus.EX_Read_data_2 = read_data_2_q;

endmodule
